// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder: word width and the
// store-buffer entry layout.
package mem_pkg;

   localparam int WORD_W = 32;
   localparam int ADDR_W = 14;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [WORD_W-1:0] data;
   } sb_entry_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Processor data-port bundle between the MEM stage and the responder,
// plus the responder's status outputs.
interface data_mem_responder_if
   import mem_pkg::*;
#(
   parameter int DEPTH = 4
);

   logic [15:0]             MemAddr;
   logic                    MemRead;
   logic                    MemWrite;
   logic [WORD_W-1:0]       WriteData;
   logic [WORD_W-1:0]       MemData;
   logic [$clog2(DEPTH):0]  BufCount;
   logic                    BufEmpty;
   logic                    AlignErr;

   modport master (
      output MemAddr, MemRead, MemWrite, WriteData,
      input  MemData, BufCount, BufEmpty, AlignErr
   );

   modport slave (
      input  MemAddr, MemRead, MemWrite, WriteData,
      output MemData, BufCount, BufEmpty, AlignErr
   );

endinterface

// File: rtl/data_mem_responder_store_buffer.sv
// Circular store buffer with valid bits and a newest-first
// combinational address lookup used for load forwarding.
module store_buffer
   import mem_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_push,
   input  logic                    i_pop,
   input  sb_entry_t               i_entry,
   input  logic [ADDR_W-1:0]       i_addr,
   output sb_entry_t               o_head,
   output logic [$clog2(DEPTH):0]  o_count,
   output logic                    o_full,
   output logic                    o_empty,
   output logic                    o_hit,
   output logic [WORD_W-1:0]       o_hit_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   sb_entry_t        r_mem [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_tail;
   logic [CW-1:0]    r_count;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
      end else begin
         if (i_pop) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + PW'(1);
         end
         // push after pop so a full push+pop re-marks the same slot valid
         if (i_push) begin
            r_valid[r_tail] <= 1'b1;
            r_tail          <= r_tail + PW'(1);
         end
         if (i_push && !i_pop)
            r_count <= r_count + CW'(1);
         else if (i_pop && !i_push)
            r_count <= r_count - CW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst_n && i_push)
         r_mem[r_tail] <= i_entry;
   end

   // valid entries are contiguous from head, so later hits are newer
   always_comb begin
      o_hit      = 1'b0;
      o_hit_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         logic [PW-1:0] idx;
         idx = r_head + PW'(i);
         if (r_valid[idx] && r_mem[idx].addr == i_addr) begin
            o_hit      = 1'b1;
            o_hit_data = r_mem[idx].data;
         end
      end
   end

   assign o_head  = r_mem[r_head];
   assign o_count = r_count;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/data_mem_responder.sv
// Zero-latency data-memory responder: word RAM behind a posted store
// buffer that drains on cycles the read port is free.
module data_mem_responder #(
   parameter int ADDR_W = 14,
   parameter int DEPTH  = 4
) (
   input  logic Clock,
   input  logic nReset,
   data_mem_responder_if.slave bus
);

   localparam int SB_AW = mem_pkg::ADDR_W;
   localparam int WW    = mem_pkg::WORD_W;

   logic [WW-1:0]          r_ram [2**ADDR_W];
   logic                   r_align;

   logic [ADDR_W-1:0]      w_wa;
   logic [SB_AW-1:0]       w_wa_ext;
   logic                   w_rd;
   logic                   w_wr;
   logic                   w_drain;
   mem_pkg::sb_entry_t     w_entry;
   mem_pkg::sb_entry_t     w_head;
   logic [$clog2(DEPTH):0] w_count;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_hit;
   logic [WW-1:0]          w_hit_data;

   assign w_wa     = bus.MemAddr[ADDR_W+1:2];
   assign w_wa_ext = SB_AW'(w_wa);

   // read+write together is handled as a write
   assign w_wr = bus.MemWrite;
   assign w_rd = bus.MemRead & ~bus.MemWrite;

   // writes only drain to make room; idle cycles drain freely
   assign w_drain = w_wr ? w_full : (~w_rd & ~w_empty);

   assign w_entry = '{addr: w_wa_ext, data: bus.WriteData};

   store_buffer #(
      .DEPTH (DEPTH)
   ) u_sb (
      .i_clk      (Clock),
      .i_rst_n    (nReset),
      .i_push     (w_wr),
      .i_pop      (w_drain),
      .i_entry    (w_entry),
      .i_addr     (w_wa_ext),
      .o_head     (w_head),
      .o_count    (w_count),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_hit      (w_hit),
      .o_hit_data (w_hit_data)
   );

   always_ff @(posedge Clock) begin
      if (nReset && w_drain)
         r_ram[w_head.addr[ADDR_W-1:0]] <= w_head.data;
   end

   always_ff @(posedge Clock) begin
      if (!nReset)
         r_align <= 1'b0;
      else if ((bus.MemRead || bus.MemWrite) && bus.MemAddr[1:0] != 2'b00)
         r_align <= 1'b1;
   end

   assign bus.MemData  = !w_rd  ? '0
                       : w_hit ? w_hit_data
                       :         r_ram[w_wa];
   assign bus.BufCount = w_count;
   assign bus.BufEmpty = w_empty;
   assign bus.AlignErr = r_align;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed table-driven bench for data_mem_responder, with hand-written
// reset and address-wrap sequences.
module tb_data_mem_responder;

   logic Clock = 1'b0;
   logic nReset;

   always #5 Clock = ~Clock;

   data_mem_responder_if #(.DEPTH(4)) bus ();
   data_mem_responder_if #(.DEPTH(4)) bus2 ();

   data_mem_responder #(.ADDR_W(14), .DEPTH(4)) dut (
      .Clock  (Clock),
      .nReset (nReset),
      .bus    (bus)
   );

   data_mem_responder #(.ADDR_W(4), .DEPTH(4)) dut2 (
      .Clock  (Clock),
      .nReset (nReset),
      .bus    (bus2)
   );

   typedef struct {
      logic        rst_n;
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_data;
      logic [2:0]  exp_cnt;
      logic        exp_al;
   } vec_t;

   vec_t vt[$];
   int   n_vec = 0;
   int   n_err = 0;

   always @(posedge Clock) begin
      if (nReset)
         assert (!(bus.MemRead && bus.MemWrite))
         else $error("illegal MemRead+MemWrite on bus");
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rst_n, input logic rd,
                               input logic wr, input logic [15:0] addr,
                               input logic [31:0] wd,
                               input logic [31:0] ed,
                               input logic [2:0] ec, input logic ea);
      vec_t v;
      v.rst_n = rst_n; v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd;
      v.exp_data = ed; v.exp_cnt = ec; v.exp_al = ea;
      return v;
   endfunction

   task automatic wr_v(input logic [15:0] a, input logic [31:0] d,
                       input logic [2:0] c, input logic al);
      vt.push_back(mk(1, 0, 1, a, d, 32'h0, c, al));
   endtask

   task automatic rd_v(input logic [15:0] a, input logic [31:0] e,
                       input logic [2:0] c, input logic al);
      vt.push_back(mk(1, 1, 0, a, 32'h0, e, c, al));
   endtask

   task automatic id_v(input logic [2:0] c, input logic al);
      vt.push_back(mk(1, 0, 0, 16'h0, 32'h0, 32'h0, c, al));
   endtask

   task automatic rs_v(input logic [2:0] c, input logic al);
      vt.push_back(mk(0, 0, 0, 16'h0, 32'h0, 32'h0, c, al));
   endtask

   task automatic build();
      // forward
      wr_v(16'h0010, 32'hDEADBEEF, 3'd0, 0);
      rd_v(16'h0010, 32'hDEADBEEF, 3'd1, 0);
      id_v(3'd1, 0);
      // newest wins, then drained in order
      wr_v(16'h0020, 32'h11111111, 3'd0, 0);
      wr_v(16'h0020, 32'h22222222, 3'd1, 0);
      rd_v(16'h0020, 32'h22222222, 3'd2, 0);
      id_v(3'd2, 0);
      id_v(3'd1, 0);
      rd_v(16'h0020, 32'h22222222, 3'd0, 0);
      // fill to DEPTH, then overflow drains oldest
      wr_v(16'h0000, 32'hA0A0A0A0, 3'd0, 0);
      rd_v(16'h0000, 32'hA0A0A0A0, 3'd1, 0);
      wr_v(16'h0004, 32'hA1A1A1A1, 3'd1, 0);
      rd_v(16'h0004, 32'hA1A1A1A1, 3'd2, 0);
      wr_v(16'h0008, 32'hA2A2A2A2, 3'd2, 0);
      rd_v(16'h0008, 32'hA2A2A2A2, 3'd3, 0);
      wr_v(16'h000C, 32'hA3A3A3A3, 3'd3, 0);
      rd_v(16'h000C, 32'hA3A3A3A3, 3'd4, 0);
      wr_v(16'h0010, 32'hA4A4A4A4, 3'd4, 0);
      rd_v(16'h0000, 32'hA0A0A0A0, 3'd4, 0);
      rd_v(16'h0010, 32'hA4A4A4A4, 3'd4, 0);
      for (int j = 0; j < 4; j++) id_v(3'(4 - j), 0);
      rd_v(16'h0010, 32'hA4A4A4A4, 3'd0, 0);
      rd_v(16'h000C, 32'hA3A3A3A3, 3'd0, 0);
      // old values, drained
      for (int j = 0; j < 4; j++)
         wr_v(16'h0100 + 16'(4 * j), 32'h0D0D0000 + 32'(j), 3'(j), 0);
      for (int j = 0; j < 4; j++) id_v(3'(4 - j), 0);
      // new values, two drained, two discarded by reset
      for (int j = 0; j < 4; j++)
         wr_v(16'h0100 + 16'(4 * j), 32'h5A5A0000 + 32'(j), 3'(j), 0);
      id_v(3'd4, 0);
      id_v(3'd3, 0);
      rs_v(3'd2, 0);
      rd_v(16'h0100, 32'h5A5A0000, 3'd0, 0);
      rd_v(16'h0104, 32'h5A5A0001, 3'd0, 0);
      rd_v(16'h0108, 32'h0D0D0002, 3'd0, 0);
      rd_v(16'h010C, 32'h0D0D0003, 3'd0, 0);
      // misaligned read, sticky flag until reset
      rd_v(16'h0013, 32'hA4A4A4A4, 3'd0, 0);
      id_v(3'd0, 1);
      rd_v(16'h0010, 32'hA4A4A4A4, 3'd0, 1);
      rs_v(3'd0, 1);
      id_v(3'd0, 0);
   endtask

   task automatic drive(input logic rd, input logic wr,
                        input logic [15:0] a, input logic [31:0] d);
      bus.MemRead   = rd;
      bus.MemWrite  = wr;
      bus.MemAddr   = a;
      bus.WriteData = d;
   endtask

   task automatic drive2(input logic rd, input logic wr,
                         input logic [15:0] a, input logic [31:0] d);
      bus2.MemRead   = rd;
      bus2.MemWrite  = wr;
      bus2.MemAddr   = a;
      bus2.WriteData = d;
   endtask

   initial begin
      build();
      nReset = 1'b0;
      drive(0, 1, 16'h0010, 32'hCAFEF00D);
      drive2(0, 0, 16'h0, 32'h0);
      repeat (2) @(posedge Clock);
      #1;
      nReset = 1'b1;
      drive(0, 0, 16'h0, 32'h0);
      @(negedge Clock);
      chk("reset.BufCount", 32'(bus.BufCount), 32'd0);
      chk("reset.BufEmpty", 32'(bus.BufEmpty), 32'd1);
      chk("reset.AlignErr", 32'(bus.AlignErr), 32'd0);
      chk("reset.MemData", bus.MemData, 32'h0);
      @(posedge Clock);
      #1;

      foreach (vt[i]) begin
         nReset = vt[i].rst_n;
         drive(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wd);
         @(negedge Clock);
         chk($sformatf("v%0d.MemData", i), bus.MemData, vt[i].exp_data);
         chk($sformatf("v%0d.BufCount", i), 32'(bus.BufCount),
             32'(vt[i].exp_cnt));
         chk($sformatf("v%0d.BufEmpty", i), 32'(bus.BufEmpty),
             32'(vt[i].exp_cnt == 3'd0));
         chk($sformatf("v%0d.AlignErr", i), 32'(bus.AlignErr),
             32'(vt[i].exp_al));
         @(posedge Clock);
         #1;
      end
      nReset = 1'b1;
      drive(0, 0, 16'h0, 32'h0);

      // ADDR_W=4: byte 0x0040 and 0x0080 alias word 0
      drive2(0, 1, 16'h0040, 32'hC0C0C0C0);
      @(negedge Clock);
      chk("wrap.cnt0", 32'(bus2.BufCount), 32'd0);
      @(posedge Clock);
      #1;
      drive2(1, 0, 16'h0000, 32'h0);
      @(negedge Clock);
      chk("wrap.fwd", bus2.MemData, 32'hC0C0C0C0);
      chk("wrap.cnt1", 32'(bus2.BufCount), 32'd1);
      @(posedge Clock);
      #1;
      drive2(0, 0, 16'h0, 32'h0);
      @(posedge Clock);
      #1;
      drive2(1, 0, 16'h0000, 32'h0);
      @(negedge Clock);
      chk("wrap.ram", bus2.MemData, 32'hC0C0C0C0);
      chk("wrap.empty", 32'(bus2.BufEmpty), 32'd1);
      @(posedge Clock);
      #1;
      drive2(1, 0, 16'h0080, 32'h0);
      @(negedge Clock);
      chk("wrap.alias", bus2.MemData, 32'hC0C0C0C0);
      @(posedge Clock);
      #1;
      drive2(0, 0, 16'h0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
